// File: rtl/game_button_debouncer.sv
// Debounces active-low game buttons into a clean level plus press/release pulses.
// Optional auto-repeat pulses while a button is held: define GAME_BTN_AUTOREPEAT_EN.
module game_button_debouncer #(
    parameter int NUM_BTN       = 4,
    parameter int CNT_WIDTH     = 14,
    parameter int REPEAT_DELAY  = 2500000,
    parameter int REPEAT_PERIOD = 500000
) (
    input  logic               clk_5mhz,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        HELD,
        CONFIRM_RELEASE
    } state_t;

`ifdef GAME_BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
`endif

    if (CNT_WIDTH < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badConfig
        $error("game_button_debouncer: CNT_WIDTH, REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;

    // Reset loads the unpushed level so no spurious press is seen after release
    always_ff @(posedge clk_5mhz) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t               r_state;
        state_t               w_stateNext;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] w_cntNext;
        logic                 w_press;
        logic                 w_release;
        logic                 r_level;
        logic                 r_press;
        logic                 r_release;

        always_comb begin
            w_stateNext = r_state;
            w_cntNext   = '0;
            w_press     = 1'b0;
            w_release   = 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_sync2[g]) w_stateNext = CONFIRM_PRESS;
                end
                CONFIRM_PRESS: begin
                    if (r_sync2[g]) begin
                        w_stateNext = IDLE;
                    end else if (&r_cnt) begin
                        w_stateNext = HELD;
                        w_press     = 1'b1;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (r_sync2[g]) w_stateNext = CONFIRM_RELEASE;
                end
                CONFIRM_RELEASE: begin
                    if (!r_sync2[g]) begin
                        w_stateNext = HELD;
                    end else if (&r_cnt) begin
                        w_stateNext = IDLE;
                        w_release   = 1'b1;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end

        always_ff @(posedge clk_5mhz) begin
            if (!rst_n) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_stateNext;
                r_cnt     <= w_cntNext;
                r_level   <= (w_stateNext == HELD) || (w_stateNext == CONFIRM_RELEASE);
                r_press   <= w_press;
                r_release <= w_release;
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;

`ifdef GAME_BTN_AUTOREPEAT_EN
        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_holdNext;
        logic              r_repDone;
        logic              w_repDoneNext;
        logic              w_repeat;
        logic              r_repeat;

        // Hold age survives a release bounce; only a fresh press restarts the delay
        always_comb begin
            w_holdNext    = '0;
            w_repDoneNext = r_repDone;
            w_repeat      = 1'b0;
            if (w_press) begin
                w_repDoneNext = 1'b0;
            end else if (r_state == HELD || r_state == CONFIRM_RELEASE) begin
                if (w_stateNext != IDLE && r_hold == (r_repDone ? PERIOD_LAST : DELAY_LAST)) begin
                    w_repeat      = 1'b1;
                    w_repDoneNext = 1'b1;
                end else begin
                    w_holdNext = r_hold + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_5mhz) begin
            if (!rst_n) begin
                r_hold    <= '0;
                r_repDone <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_hold    <= w_holdNext;
                r_repDone <= w_repDoneNext;
                r_repeat  <= w_repeat;
            end
        end

        assign btn_repeat[g] = r_repeat;
`else
        assign btn_repeat[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_game_button_debouncer.sv
// Randomized self-checking bench for game_button_debouncer against a run-length reference model.
// Compile with GAME_BTN_AUTOREPEAT_EN defined to also check the auto-repeat pulses.
module tb_game_button_debouncer;

    localparam int NUM_BTN    = 4;
    localparam int CNT_W      = 3;
    localparam int DEB_LEN    = 1 << CNT_W;
    localparam int REP_DELAY  = 20;
    localparam int REP_PERIOD = 5;

    logic               clk;
    logic               rstN;
    logic [NUM_BTN-1:0] btnRawN;
    logic [NUM_BTN-1:0] btnLevel;
    logic [NUM_BTN-1:0] btnPress;
    logic [NUM_BTN-1:0] btnRelease;
    logic [NUM_BTN-1:0] btnRepeat;

    int numChecks = 0;
    int numFails  = 0;
    int cycle     = 0;

    // Reference model state: delayed pin copies, run length of disagreement, hold age
    logic [NUM_BTN-1:0] mSync1;
    logic [NUM_BTN-1:0] mSync2;
    logic [NUM_BTN-1:0] expLevel;
    logic [NUM_BTN-1:0] expPress;
    logic [NUM_BTN-1:0] expRelease;
    logic [NUM_BTN-1:0] expRepeat;
    int                 mRun [NUM_BTN];
    int                 mAge [NUM_BTN];
    int                 holdLeft [NUM_BTN];

    game_button_debouncer #(
        .NUM_BTN      (NUM_BTN),
        .CNT_WIDTH    (CNT_W),
        .REPEAT_DELAY (REP_DELAY),
        .REPEAT_PERIOD(REP_PERIOD)
    ) dut (
        .clk_5mhz   (clk),
        .rst_n      (rstN),
        .btn_raw_n  (btnRawN),
        .btn_level  (btnLevel),
        .btn_press  (btnPress),
        .btn_release(btnRelease),
        .btn_repeat (btnRepeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [NUM_BTN-1:0] actual,
                               input logic [NUM_BTN-1:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cycle, actual, expected);
        end
    endtask

    // A level change is confirmed once the synchronized pin has disagreed with the
    // current level on DEB_LEN+1 consecutive edges; repeats fall at fixed hold ages.
    task automatic modelStep();
        logic wasHeld;
        logic toggled;
        for (int i = 0; i < NUM_BTN; i++) begin
            expPress[i]   = 1'b0;
            expRelease[i] = 1'b0;
            expRepeat[i]  = 1'b0;
            if (!rstN) begin
                mRun[i]     = 0;
                mAge[i]     = 0;
                expLevel[i] = 1'b0;
            end else begin
                wasHeld = expLevel[i];
                toggled = 1'b0;
                if ((mSync2[i] == 1'b0) != expLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DEB_LEN + 1) begin
                        toggled     = 1'b1;
                        mRun[i]     = 0;
                        expLevel[i] = ~expLevel[i];
                        if (expLevel[i]) expPress[i] = 1'b1;
                        else             expRelease[i] = 1'b1;
                    end
                end else begin
                    mRun[i] = 0;
                end
                if (wasHeld) begin
                    mAge[i]++;
`ifdef GAME_BTN_AUTOREPEAT_EN
                    if (!toggled && mAge[i] >= REP_DELAY && (mAge[i] - REP_DELAY) % REP_PERIOD == 0)
                        expRepeat[i] = 1'b1;
`endif
                end
                if (expPress[i]) mAge[i] = 0;
            end
        end
        if (!rstN) begin
            mSync1 = '1;
            mSync2 = '1;
        end else begin
            mSync2 = mSync1;
            mSync1 = btnRawN;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] raw, input logic rst);
        btnRawN = raw;
        rstN    = rst;
        @(posedge clk);
        modelStep();
        cycle++;
        #1;
        checkOutput("level",   btnLevel,   expLevel);
        checkOutput("press",   btnPress,   expPress);
        checkOutput("release", btnRelease, expRelease);
        checkOutput("repeat",  btnRepeat,  expRepeat);
    endtask

    task automatic holdFor(input logic [NUM_BTN-1:0] raw, input int n);
        for (int k = 0; k < n; k++) applyStimulus(raw, 1'b1);
    endtask

    initial begin
        mSync1   = '1;
        mSync2   = '1;
        expLevel = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            mRun[i]     = 0;
            mAge[i]     = 0;
            holdLeft[i] = 0;
        end

        for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 1'b0);
        holdFor(4'b1111, 3);

        // Single press held, then released cleanly
        holdFor(4'b1110, 14);
        holdFor(4'b1111, 14);

        // Short glitch must not confirm
        holdFor(4'b1101, 5);
        holdFor(4'b1111, 12);

        // Bouncing release on button 2
        holdFor(4'b1011, 14);
        holdFor(4'b1111, 1);
        holdFor(4'b1011, 1);
        holdFor(4'b1111, 1);
        holdFor(4'b1011, 1);
        holdFor(4'b1111, 14);

        // All buttons together, held long enough for several repeats
        holdFor(4'b0000, 14);
        holdFor(4'b0000, 40);
        holdFor(4'b1111, 20);

        // Reset while confirming a release, button pushed again through reset
        holdFor(4'b0111, 14);
        holdFor(4'b1111, 5);
        applyStimulus(4'b0111, 1'b0);
        holdFor(4'b0111, 14);
        holdFor(4'b1111, 14);

        // Random bouncy and long presses with occasional resets
        for (int c = 0; c < 1500; c++) begin
            logic [NUM_BTN-1:0] raw;
            raw = btnRawN;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (holdLeft[i] == 0) begin
                    raw[i]      = ~raw[i];
                    holdLeft[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                                              : $urandom_range(8, 60);
                end
                holdLeft[i]--;
            end
            applyStimulus(raw, ($urandom_range(0, 399) != 0));
        end
        holdFor(4'b1111, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
